// File: rtl/dfr_step_if.sv
// Step request bus between the phase sequencer and the reservoir datapath.
// The master side issues step requests and the slave side accepts them.
interface dfr_step_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 step_valid;
  logic                 step_ready;
  logic [1:0]           phase;
  logic [CNT_WIDTH-1:0] sample_addr;
  logic                 first_step;
  logic                 last_step;

  modport master (
    output step_valid,
    output phase,
    output sample_addr,
    output first_step,
    output last_step,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  phase,
    input  sample_addr,
    input  first_step,
    input  last_step,
    output step_ready
  );
endinterface

// File: rtl/dfr_phase_sequencer.sv
// Runs the reservoir through its INIT, TRAIN and TEST phases, issuing one step
// request per time-step together with the global sample address of that step.
module dfr_phase_sequencer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_init_samples,
  input  logic [CNT_WIDTH-1:0] num_init_steps,
  input  logic [CNT_WIDTH-1:0] num_train_samples,
  input  logic [CNT_WIDTH-1:0] num_train_steps,
  input  logic [CNT_WIDTH-1:0] num_test_samples,
  input  logic [CNT_WIDTH-1:0] num_test_steps,
  input  logic [CNT_WIDTH-1:0] num_steps_per_sample,
  dfr_step_if.master           step_bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_TRAIN,
    ST_TEST,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Index 0 = INIT, 1 = TRAIN, 2 = TEST throughout.
  logic [2:0][CNT_WIDTH-1:0] samples_in, steps_in;
  logic [2:0][CNT_WIDTH-1:0] samples_reg, steps_reg;
  logic [CNT_WIDTH-1:0]      sps_reg;
  logic [2:0]                empty_in, empty_reg;

  logic [CNT_WIDTH-1:0] step_in_sample_reg;
  logic [CNT_WIDTH-1:0] sample_cnt_reg;
  logic [CNT_WIDTH-1:0] total_steps_reg;

  logic                 in_phase;
  logic [1:0]           cur_idx;
  logic [CNT_WIDTH-1:0] cur_samples, cur_steps, phase_base;
  logic                 start_accept, accept, last_in_sample, phase_end;

  assign samples_in = {num_test_samples, num_train_samples, num_init_samples};
  assign steps_in   = {num_test_steps, num_train_steps, num_init_steps};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_phase
      assign empty_in[gi]  = (samples_in[gi] == '0) || (steps_in[gi] == '0);
      assign empty_reg[gi] = (samples_reg[gi] == '0) || (steps_reg[gi] == '0);
    end
  endgenerate

  function automatic state_t idx_to_state(input int idx);
    case (idx)
      0:       return ST_INIT;
      1:       return ST_TRAIN;
      2:       return ST_TEST;
      default: return ST_DONE;
    endcase
  endfunction

  // First non-empty phase at or after index 'from'; DONE if none remain.
  function automatic state_t pick_phase(input logic [2:0] empty, input int from);
    state_t s;
    s = ST_DONE;
    for (int i = 2; i >= 0; i--) begin
      if (i >= from && !empty[i]) s = idx_to_state(i);
    end
    return s;
  endfunction

  always_comb begin
    in_phase = 1'b0;
    cur_idx  = 2'd0;
    case (state_reg)
      ST_INIT:  begin in_phase = 1'b1; cur_idx = 2'd0; end
      ST_TRAIN: begin in_phase = 1'b1; cur_idx = 2'd1; end
      ST_TEST:  begin in_phase = 1'b1; cur_idx = 2'd2; end
      default:  begin in_phase = 1'b0; cur_idx = 2'd0; end
    endcase
  end

  assign cur_samples    = samples_reg[cur_idx];
  assign cur_steps      = steps_reg[cur_idx];
  assign start_accept   = (state_reg == ST_IDLE) && start;
  assign accept         = in_phase && step_bus.step_ready;
  assign last_in_sample = (step_in_sample_reg == sps_reg - ONE);
  assign phase_end      = accept &&
                          ((total_steps_reg + ONE == cur_steps) ||
                           (last_in_sample && (sample_cnt_reg == cur_samples - ONE)));

  // Bases use the latched counts even when an earlier phase was skipped.
  always_comb begin
    phase_base = '0;
    case (cur_idx)
      2'd1:    phase_base = samples_reg[0];
      2'd2:    phase_base = samples_reg[0] + samples_reg[1];
      default: phase_base = '0;
    endcase
  end

  always_comb begin
    state_next           = state_reg;
    step_bus.step_valid  = in_phase;
    step_bus.phase       = in_phase ? cur_idx + 2'd1 : 2'd0;
    step_bus.sample_addr = in_phase ? phase_base + sample_cnt_reg : '0;
    step_bus.first_step  = in_phase && (step_in_sample_reg == '0);
    step_bus.last_step   = in_phase && last_in_sample;
    busy                 = (state_reg != ST_IDLE);
    done                 = (state_reg == ST_DONE);
    case (state_reg)
      ST_IDLE:  if (start) state_next = pick_phase(empty_in, 0);
      ST_INIT, ST_TRAIN, ST_TEST:
                if (phase_end) state_next = pick_phase(empty_reg, int'(cur_idx) + 1);
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      samples_reg <= '0;
      steps_reg   <= '0;
      sps_reg     <= ONE;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        samples_reg <= samples_in;
        steps_reg   <= steps_in;
        sps_reg     <= (num_steps_per_sample == '0) ? ONE : num_steps_per_sample;
      end
    end
  end

  // Any state change clears the counters, so every phase starts from zero.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state_reg)) begin
      step_in_sample_reg <= '0;
      sample_cnt_reg     <= '0;
      total_steps_reg    <= '0;
    end else if (accept) begin
      total_steps_reg <= total_steps_reg + ONE;
      if (last_in_sample) begin
        step_in_sample_reg <= '0;
        sample_cnt_reg     <= sample_cnt_reg + ONE;
      end else begin
        step_in_sample_reg <= step_in_sample_reg + ONE;
      end
    end
  end

endmodule

// File: doc/dfr_phase_sequencer.md
Name: dfr_phase_sequencer

Overview:
- Consumes the run configuration written over AXI: the ctrl start bit and the init, train and test sample and step counts.
- Sequences the reservoir datapath through the INIT, TRAIN and TEST phases.
- Issues one step request per reservoir time-step and produces the sample address for each step.
- Returns the busy level that the register block folds into ctrl bit 1.

Parameters:
CNT_WIDTH, 32, width of all count inputs, internal counters and sample_addr.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  run request (ctrl[0]); registered start bit, high for one cycle per write.
num_init_samples  in  CNT_WIDTH  samples in INIT phase.
num_init_steps  in  CNT_WIDTH  step budget of INIT phase.
num_train_samples  in  CNT_WIDTH  samples in TRAIN phase.
num_train_steps  in  CNT_WIDTH  step budget of TRAIN phase.
num_test_samples  in  CNT_WIDTH  samples in TEST phase.
num_test_steps  in  CNT_WIDTH  step budget of TEST phase.
num_steps_per_sample  in  CNT_WIDTH  reservoir steps per input sample.
step_ready  in  1  datapath accepts current step.
step_valid  out  1  step request to datapath.
phase  out  2  0 = idle, 1 = init, 2 = train, 3 = test.
sample_addr  out  CNT_WIDTH  global sample index for the current step.
first_step  out  1  current step is step 0 of its sample.
last_step  out  1  current step is the final step of its sample.
busy  out  1  run in progress.
done  out  1  one-cycle pulse at end of run.

Behaviour:
Reset:
- Reset is synchronous, active-high.
- All outputs reset to 0 and the FSM goes to IDLE.
- Reset mid-run aborts immediately: no done pulse, counters cleared.

Configuration latch:
- On start accepted in IDLE, all nine count inputs are captured into shadow registers.
- Later input changes have no effect until the next start.
- num_steps_per_sample == 0 is treated as 1.

FSM states and transitions:
- IDLE -> first non-empty phase of INIT, TRAIN, TEST on start; -> DONE if all phases are empty.
- INIT, TRAIN, TEST -> next non-empty phase, or DONE, when the phase end condition is met on an accepted step.
- DONE -> IDLE unconditionally after one cycle.
- A phase is empty when its num_X_steps == 0 or its num_X_samples == 0. Empty phases are skipped with zero cycles spent in them.
- start while not in IDLE is ignored (no queueing).
- start on the same cycle as rst: rst wins.

Step handshake:
- In a phase state, step_valid = 1 continuously.
- A step is accepted on a cycle with step_valid & step_ready.
- Outputs are held stable while step_valid & !step_ready.
- First step_valid appears the cycle after start (latency 1).

Counters (per phase, cleared on phase entry):
- step_in_sample: increments on accept. On reaching sps-1 and accepting, it wraps to 0 and sample_cnt increments.
- total_steps: increments on every accept.
- The phase ends on the accept where total_steps+1 == num_X_steps, or where the step is the last step of sample num_X_samples-1, whichever occurs first.

Outputs:
- sample_addr = phase_base + sample_cnt, modulo 2^CNT_WIDTH.
- phase_base is 0 for INIT, init_samples for TRAIN, and init_samples + train_samples for TEST. It uses the latched counts whether or not earlier phases were skipped.
- first_step = (step_in_sample == 0); last_step = (step_in_sample == sps-1). Both are gated by step_valid.
- phase output reflects the current state; it is 0 in IDLE and DONE.
- busy = 1 in every state except IDLE, including the DONE cycle.
- done = 1 only in DONE.

Test Plan:
- Basic run: init = 2 samples / 4 steps, train = 1/2, test = 1/2, sps = 2, step_ready tied 1. Required: start at cycle 0; step_valid cycles 1-8; sample_addr sequence 0,0,1,1,2,2,3,3; phase sequence 1×4, 2×2, 3×2; done at cycle 9; busy cycles 1-9.
- Backpressure: same config, step_ready toggles 1,0. Required: each step held for 2 cycles with stable sample_addr and first_step/last_step; 8 accepts total; done follows the 8th accept.
- Skip and budget: train_steps = 0, test = 3 samples / 4 steps, sps = 2, init = 1/2. Required: INIT to TEST directly; TEST ends after 4 steps with sample_addr 1,1,2,2 (base = 1 + 0); done asserted.
- Edge config: all counts 0. Required: start gives done = 1 and busy = 1 at cycle 1, IDLE at cycle 2, step_valid never high. sps = 0 with init = 2/2 gives 2 steps, both with first_step = last_step = 1, sample_addr 0 and 1.
- Start mid-run and config change: pulse start and change num_test_steps during TRAIN. Required: no restart; original counts are used; total step count unchanged.
- Reset mid-run: assert rst during TRAIN at step 1. Required: next cycle busy = 0, step_valid = 0, phase = 0, no done pulse. A new start then runs from sample_addr 0.
